// File: rtl/spgd_pkg.sv
// spgd_pkg: shared definitions for the SPGD dither sequencer.
//   state_t      - sequencer state encoding
//   LFSR_TAPS    - feedback mask for the x^16+x^14+x^13+x^11+1 Fibonacci LFSR
//   DEFAULT_SEED - seed substituted when a zero seed is supplied
//   FRAC_W       - fraction bits of the Q16.16 metric/gain words
package spgd_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_APPLY_P, S_SETTLE_P, S_MEAS_P, S_CAPT_P,
    S_APPLY_M, S_SETTLE_M, S_MEAS_M, S_CAPT_M, S_UPDATE, S_ERROR
  } state_t;

  // Shift-right form: polynomial tap t feeds from bit 16-t (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS    = 16'h002D;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam int          FRAC_W       = 16;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {^(l & LFSR_TAPS), l[15:1]};
  endfunction

endpackage

// File: rtl/dac_sat_add.sv
// dac_sat_add: unsigned DAC code plus signed offset, saturated to the code range.
//   i_base - current code (unsigned)
//   i_off  - signed offset, magnitude at most 2^DAC_WIDTH-1
//   o_sum  - result clamped to [0, 2^DAC_WIDTH-1]
module dac_sat_add #(
  parameter int DAC_WIDTH = 14
)(
  input  logic [DAC_WIDTH-1:0]  i_base,
  input  logic signed [DAC_WIDTH:0] i_off,
  output logic [DAC_WIDTH-1:0]  o_sum
);

  // Two extra bits hold both underflow (sign) and overflow (bit DAC_WIDTH).
  logic signed [DAC_WIDTH+1:0] w_sum;

  assign w_sum = $signed({2'b00, i_base}) + $signed({i_off[DAC_WIDTH], i_off});

  always_comb begin
    o_sum = w_sum[DAC_WIDTH-1:0];
    if (w_sum[DAC_WIDTH+1])  o_sum = '0;
    else if (w_sum[DAC_WIDTH]) o_sum = '1;
  end

endmodule

// File: rtl/spgd_dither_seq.sv
// spgd_dither_seq: two-sided dither SPGD sequencer for a single DAC channel.
//   Applies base+s*AMP, settles, measures, applies base-s*AMP, settles, measures,
//   then steps base by s*((Jp-Jm)*GAIN_MU >>> 32). s comes from a 16-bit LFSR.
//   Inputs : ADC_CLK, RST (async high), START, STOP, BASE_INIT, DITHER_AMP,
//            GAIN_MU, LFSR_SEED, ADC_DONE, METRIC_IN
//   Outputs: ADC_EN, DAC_CODE_OUT, BUSY, ERR (sticky timeout), ITER_COUNT
module spgd_dither_seq
  import spgd_pkg::*;
#(
  parameter int FP_WIDTH       = 32,
  parameter int DAC_WIDTH      = 14,
  parameter int SETTLE_CYCLES  = 64,
  parameter int TIMEOUT_CYCLES = 65535
)(
  input  logic                 ADC_CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic                 STOP,
  input  logic [DAC_WIDTH-1:0] BASE_INIT,
  input  logic [DAC_WIDTH-1:0] DITHER_AMP,
  input  logic [FP_WIDTH-1:0]  GAIN_MU,
  input  logic [15:0]          LFSR_SEED,
  input  logic                 ADC_DONE,
  input  logic [FP_WIDTH-1:0]  METRIC_IN,
  output logic                 ADC_EN,
  output logic [DAC_WIDTH-1:0] DAC_CODE_OUT,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [15:0]          ITER_COUNT
);

  localparam int PW = 2*FP_WIDTH + 1;
  localparam logic [31:0] SETTLE_LAST  = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic signed [PW-1:0] STEP_MAX = PW'((1 << DAC_WIDTH) - 1);
  localparam logic signed [PW-1:0] STEP_MIN = -STEP_MAX;

  state_t r_state, w_next;
  logic [31:0]          r_cnt;
  logic [DAC_WIDTH-1:0] r_base, r_dac;
  logic [15:0]          r_lfsr, r_iter;
  logic [FP_WIDTH-1:0]  r_jp, r_jm;
  logic                 r_err, r_stop;

  logic                       w_s, w_load;
  logic signed [FP_WIDTH:0]   w_d;
  logic signed [PW-1:0]       w_prod, w_sh;
  logic signed [DAC_WIDTH:0]  w_step, w_amp, w_off;
  logic [DAC_WIDTH-1:0]       w_sum;

  assign DAC_CODE_OUT = r_dac;
  assign ERR          = r_err;
  assign ITER_COUNT   = r_iter;

  assign w_s    = r_lfsr[0];
  assign w_load = (r_state == S_IDLE || r_state == S_ERROR) && START && !STOP;

  // Q16.16 * Q16.16 -> Q32.32; dropping 32 fraction bits leaves whole DAC codes.
  assign w_d    = $signed({r_jp[FP_WIDTH-1], r_jp}) - $signed({r_jm[FP_WIDTH-1], r_jm});
  assign w_prod = PW'(w_d) * PW'($signed(GAIN_MU));
  assign w_sh   = w_prod >>> (2*FRAC_W);
  assign w_step = (w_sh > STEP_MAX) ? STEP_MAX[DAC_WIDTH:0] :
                  (w_sh < STEP_MIN) ? STEP_MIN[DAC_WIDTH:0] : w_sh[DAC_WIDTH:0];
  assign w_amp  = $signed({1'b0, DITHER_AMP});

  // One shared saturating adder: dither offset in APPLY_x, gradient step in UPDATE.
  always_comb begin
    w_off = '0;
    case (r_state)
      S_APPLY_P: w_off = w_s ? w_amp : -w_amp;
      S_APPLY_M: w_off = w_s ? -w_amp : w_amp;
      default:   w_off = w_s ? w_step : -w_step;
    endcase
  end

  dac_sat_add #(.DAC_WIDTH(DAC_WIDTH)) u_add (
    .i_base (r_base),
    .i_off  (w_off),
    .o_sum  (w_sum)
  );

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    ADC_EN = 1'b0;
    BUSY   = 1'b1;
    case (r_state)
      S_IDLE, S_ERROR: begin
        BUSY = 1'b0;
        if (w_load) w_next = S_APPLY_P;
      end
      S_APPLY_P:  w_next = S_SETTLE_P;
      S_SETTLE_P: if (r_cnt == SETTLE_LAST) w_next = S_MEAS_P;
      S_MEAS_P: begin
        ADC_EN = 1'b1;
        if (ADC_DONE)                   w_next = S_CAPT_P;
        else if (r_cnt == TIMEOUT_LAST) w_next = S_ERROR;
      end
      S_CAPT_P:   w_next = S_APPLY_M;
      S_APPLY_M:  w_next = S_SETTLE_M;
      S_SETTLE_M: if (r_cnt == SETTLE_LAST) w_next = S_MEAS_M;
      S_MEAS_M: begin
        ADC_EN = 1'b1;
        if (ADC_DONE)                   w_next = S_CAPT_M;
        else if (r_cnt == TIMEOUT_LAST) w_next = S_ERROR;
      end
      S_CAPT_M:   w_next = S_UPDATE;
      // STOP in the UPDATE cycle itself also counts as seen this iteration.
      S_UPDATE:   w_next = (r_stop || STOP) ? S_IDLE : S_APPLY_P;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      r_cnt  <= '0;
      r_base <= '0;
      r_dac  <= '0;
      r_lfsr <= DEFAULT_SEED;
      r_jp   <= '0;
      r_jm   <= '0;
      r_err  <= 1'b0;
      r_iter <= '0;
      r_stop <= 1'b0;
    end else begin
      // Counter restarts on every state change, so SETTLE/MEAS see 0 on entry.
      r_cnt <= (w_next != r_state) ? '0 : r_cnt + 32'd1;

      if (BUSY && STOP)       r_stop <= 1'b1;
      if (w_next == S_IDLE)   r_stop <= 1'b0;

      case (r_state)
        S_IDLE, S_ERROR: if (w_load) begin
          r_base <= BASE_INIT;
          r_lfsr <= (LFSR_SEED == 16'h0) ? DEFAULT_SEED : LFSR_SEED;
          r_err  <= 1'b0;
          r_iter <= '0;
          r_stop <= 1'b0;
        end
        S_APPLY_P, S_APPLY_M: r_dac <= w_sum;
        S_MEAS_P, S_MEAS_M: if (w_next == S_ERROR) begin
          r_err <= 1'b1;
          r_dac <= r_base;
        end
        S_CAPT_P: r_jp <= METRIC_IN;
        S_CAPT_M: r_jm <= METRIC_IN;
        S_UPDATE: begin
          r_base <= w_sum;
          r_dac  <= w_sum;
          r_lfsr <= lfsr_next(r_lfsr);
          r_iter <= r_iter + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spgd_dither_seq.sv
module tb_spgd_dither_seq;

  localparam int SET  = 4;
  localparam int TO   = 16;
  localparam int DW   = 14;
  localparam int FW   = 32;
  localparam int DMAX = (1 << DW) - 1;

  logic          ADC_CLK, RST, START, STOP, ADC_DONE;
  logic [DW-1:0] BASE_INIT, DITHER_AMP;
  logic [FW-1:0] GAIN_MU, METRIC_IN;
  logic [15:0]   LFSR_SEED;
  logic          ADC_EN, BUSY, ERR;
  logic [DW-1:0] DAC_CODE_OUT;
  logic [15:0]   ITER_COUNT;

  spgd_dither_seq #(.FP_WIDTH(FW), .DAC_WIDTH(DW), .SETTLE_CYCLES(SET), .TIMEOUT_CYCLES(TO)) dut (
    .ADC_CLK(ADC_CLK), .RST(RST), .START(START), .STOP(STOP),
    .BASE_INIT(BASE_INIT), .DITHER_AMP(DITHER_AMP), .GAIN_MU(GAIN_MU),
    .LFSR_SEED(LFSR_SEED), .ADC_DONE(ADC_DONE), .METRIC_IN(METRIC_IN),
    .ADC_EN(ADC_EN), .DAC_CODE_OUT(DAC_CODE_OUT), .BUSY(BUSY), .ERR(ERR),
    .ITER_COUNT(ITER_COUNT)
  );

  initial begin
    ADC_CLK = 1'b0;
    forever #5 ADC_CLK = ~ADC_CLK;
  end

  int n_tests = 0, n_fail = 0;

  // Model state: what the outputs must be in the current cycle.
  bit          exp_en, exp_busy, m_err, m_stop;
  int          exp_dac, m_base, m_amp, m_iter, m_plus, m_minus;
  logic [15:0] m_lfsr;
  logic [31:0] m_gain;

  task automatic cmp(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v < 0) ? 0 : ((v > DMAX) ? DMAX : v);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    logic fb;
    fb = l[16-16] ^ l[16-14] ^ l[16-13] ^ l[16-11];
    return {fb, l[15:1]};
  endfunction

  // floor((Jp-Jm)*mu) in whole codes, clamped to +/-DMAX. Bench values keep
  // the product well inside 64 bits.
  function automatic int step_of(input logic [31:0] jp, input logic [31:0] jm, input logic [31:0] g);
    longint d, p, st;
    d  = longint'($signed(jp)) - longint'($signed(jm));
    p  = d * longint'($signed(g));
    st = p >>> 32;
    if (st > DMAX)  st = DMAX;
    if (st < -DMAX) st = -DMAX;
    return int'(st);
  endfunction

  // Every cycle: compare DUT against the model's view of this cycle.
  always @(negedge ADC_CLK) begin
    cmp("adc_en", int'(ADC_EN), int'(exp_en));
    cmp("busy",   int'(BUSY),   int'(exp_busy));
    cmp("dac",    int'(DAC_CODE_OUT), exp_dac);
    cmp("err",    int'(ERR),    int'(m_err));
    cmp("iter",   int'(ITER_COUNT), m_iter & 16'hFFFF);
  end

  task automatic step1(input bit en, input bit busy, input int dac);
    @(posedge ADC_CLK); #1;
    exp_en = en; exp_busy = busy; exp_dac = dac;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step1(1'b0, 1'b0, exp_dac);
  endtask

  task automatic do_start(input int base, input int amp, input logic [15:0] seed, input logic [31:0] g);
    BASE_INIT = DW'(base); DITHER_AMP = DW'(amp); LFSR_SEED = seed; GAIN_MU = g;
    START = 1'b1;
    step1(1'b0, 1'b1, exp_dac);
    START  = 1'b0;
    m_amp  = amp; m_gain = g; m_base = base;
    m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
    m_iter = 0; m_err = 1'b0; m_stop = 1'b0;
  endtask

  // Entered with the DUT in APPLY_P. Leaves it in the next APPLY_P or IDLE
  // (or ERROR / reset for the fault options).
  task automatic iterate(input logic [31:0] jp, input logic [31:0] jm, input int lat_p,
                         input int lat_m, input bit stop_p, input bit to_p, input bit rst_mm);
    int s, pv, mv, nb;
    s  = m_lfsr[0] ? 1 : -1;
    pv = sat(m_base + s*m_amp);
    mv = sat(m_base - s*m_amp);
    m_plus = pv; m_minus = mv;
    ADC_DONE = 1'b1;                      // stray pulse outside MEAS
    for (int i = 0; i < SET; i++) begin
      step1(1'b0, 1'b1, pv);
      ADC_DONE = 1'b0;
    end
    METRIC_IN = ~jp;
    if (to_p) begin
      for (int i = 0; i < TO; i++) step1(1'b1, 1'b1, pv);
      step1(1'b0, 1'b0, m_base);
      m_err = 1'b1;
      return;
    end
    for (int i = 0; i <= lat_p; i++) begin
      step1(1'b1, 1'b1, pv);
      ADC_DONE = (i == lat_p);
    end
    step1(1'b0, 1'b1, pv);                // CAPT_P
    ADC_DONE = 1'b0; METRIC_IN = jp;
    step1(1'b0, 1'b1, pv);                // APPLY_M
    METRIC_IN = 32'hDEAD_BEEF;
    for (int i = 0; i < SET; i++) begin
      step1(1'b0, 1'b1, mv);
      STOP = stop_p && (i == 0);
      if (STOP) m_stop = 1'b1;
    end
    STOP = 1'b0;
    METRIC_IN = ~jm;
    if (rst_mm) begin
      step1(1'b1, 1'b1, mv);
      #1 RST = 1'b1;
      exp_en = 1'b0; exp_busy = 1'b0; exp_dac = 0;
      m_iter = 0; m_err = 1'b0; m_base = 0; m_lfsr = 16'hACE1; m_stop = 1'b0;
      #1;
      cmp("rst_mm_adc_en", int'(ADC_EN), 0);
      cmp("rst_mm_dac",    int'(DAC_CODE_OUT), 0);
      cmp("rst_mm_iter",   int'(ITER_COUNT), 0);
      cmp("rst_mm_busy",   int'(BUSY), 0);
      return;
    end
    for (int i = 0; i <= lat_m; i++) begin
      step1(1'b1, 1'b1, mv);
      ADC_DONE = (i == lat_m);
    end
    step1(1'b0, 1'b1, mv);                // CAPT_M
    ADC_DONE = 1'b0; METRIC_IN = jm;
    step1(1'b0, 1'b1, mv);                // UPDATE
    METRIC_IN = 32'h0BAD_F00D;
    nb = sat(m_base + s*step_of(jp, jm, m_gain));
    step1(1'b0, !m_stop, nb);
    m_base = nb; m_iter++; m_lfsr = lfsr_step(m_lfsr);
    if (m_stop) m_stop = 1'b0;
  endtask

  initial begin
    RST = 1'b1; START = 1'b0; STOP = 1'b0; ADC_DONE = 1'b0;
    BASE_INIT = '0; DITHER_AMP = '0; GAIN_MU = '0; METRIC_IN = '0; LFSR_SEED = '0;
    exp_en = 1'b0; exp_busy = 1'b0; exp_dac = 0;
    m_err = 1'b0; m_iter = 0; m_base = 0; m_stop = 1'b0; m_lfsr = 16'hACE1;
    m_amp = 0; m_gain = '0; m_plus = 0; m_minus = 0;

    // Reset state
    idle_cycles(2);
    cmp("reset_dac", int'(DAC_CODE_OUT), 0);
    cmp("reset_busy", int'(BUSY), 0);
    RST = 1'b0;
    idle_cycles(2);

    // Nominal iteration, STOP pulse in SETTLE_M -> finishes, then IDLE
    do_start(8000, 100, 16'hACE1, 32'h0064_0000);
    iterate(32'h0002_0000, 32'h0001_0000, 0, 0, 1'b1, 1'b0, 1'b0);
    cmp("lit_plus_8100", m_plus, 8100);
    cmp("lit_minus_7900", m_minus, 7900);
    cmp("lit_base_8100", int'(DAC_CODE_OUT), 8100);
    cmp("lit_iter_1", int'(ITER_COUNT), 1);
    cmp("lit_idle_after_stop", int'(BUSY), 0);
    idle_cycles(3);

    // Zero seed, negative fractional step (floor), then a chained s=0 iteration
    do_start(8000, 100, 16'h0000, 32'h0003_0000);
    iterate(32'h0000_8000, 32'h0001_0000, 3, 1, 1'b0, 1'b0, 1'b0);
    cmp("lit_floor_base_7998", m_base, 7998);
    cmp("lit_lfsr_5670", int'(m_lfsr), 16'h5670);
    iterate(32'h0003_0000, 32'h0001_0000, 0, 2, 1'b1, 1'b0, 1'b0);
    cmp("lit_s0_plus_7898", m_plus, 7898);
    cmp("lit_s0_base_7992", int'(DAC_CODE_OUT), 7992);
    cmp("lit_iter_2", int'(ITER_COUNT), 2);

    // START and STOP together in IDLE: stay idle
    START = 1'b1; STOP = 1'b1;
    idle_cycles(3);
    START = 1'b0; STOP = 1'b0;
    cmp("start_stop_busy", int'(BUSY), 0);
    idle_cycles(1);

    // Upper saturation on the +phase and on a clamped step
    do_start(16350, 100, 16'hACE1, 32'h7FFF_0000);
    iterate(32'h0001_0000, 32'h0000_0000, 0, 0, 1'b1, 1'b0, 1'b0);
    cmp("lit_sat_plus", m_plus, 16383);
    cmp("lit_sat_base_hi", int'(DAC_CODE_OUT), 16383);

    // Lower saturation on the -phase and on the step
    do_start(50, 100, 16'hACE1, 32'h0064_0000);
    iterate(32'h0000_0000, 32'h0001_0000, 1, 0, 1'b1, 1'b0, 1'b0);
    cmp("lit_sat_minus", m_minus, 0);
    cmp("lit_sat_base_lo", int'(DAC_CODE_OUT), 0);

    // ADC timeout in MEAS_P with s=0 -> ERROR; stray ADC_DONE there is ignored
    do_start(1000, 10, 16'h0002, 32'h0001_0000);
    iterate(32'h0, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0);
    cmp("lit_s0_plus_990", m_plus, 990);
    cmp("lit_err_set", int'(ERR), 1);
    cmp("lit_err_busy", int'(BUSY), 0);
    cmp("lit_err_dac_base", int'(DAC_CODE_OUT), 1000);
    ADC_DONE = 1'b1;
    idle_cycles(2);
    ADC_DONE = 1'b0;
    idle_cycles(1);

    // START leaves ERROR; then reset in the middle of MEAS_M
    do_start(2000, 10, 16'hACE1, 32'h0001_0000);
    cmp("lit_err_cleared", int'(ERR), 0);
    iterate(32'h0005_0000, 32'h0001_0000, 0, 0, 1'b0, 1'b0, 1'b0);
    cmp("lit_base_2004", m_base, 2004);
    iterate(32'h0001_0000, 32'h0001_0000, 0, 0, 1'b0, 1'b0, 1'b1);
    idle_cycles(2);
    RST = 1'b0;
    idle_cycles(2);

    // Recovery after reset
    do_start(300, 5, 16'hACE1, 32'h0001_0000);
    iterate(32'h0002_0000, 32'h0000_0000, 0, 0, 1'b1, 1'b0, 1'b0);
    cmp("lit_recover_base_302", int'(DAC_CODE_OUT), 302);
    idle_cycles(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
